// File: rtl/legv8_control_fsm.sv
// ---------------------------------------------------------------------------
// legv8_control_fsm
//
// Multi-cycle control unit for the 64-bit LEGv8 datapath. It latches the
// instruction word coming back from instruction memory, steps through
// FETCH / DECODE / EXEC / MEM and drives the full datapath control word.
// Unsupported opcodes park the unit in TRAP with a sticky illegal flag until
// the next reset.
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous, active-low reset
//   run        1 = leave FETCH and execute, 0 = stall in FETCH
//   instr      instruction word from the datapath, sampled in FETCH
//   status     {V,C,N,Z} from the datapath ALU (combinational)
//   k          immediate / branch offset onto the datapath
//   DA,SA,SB   destination / source A / source B register selects
//   FS         ALU function select {op[2:0],invA,invB}
//   PS         PC operation: 0000 hold, 0001 PC+4, 0010 load target
//   PCsel      branch target source: 0 = PC+k, 1 = A bus
//   dataMux    register write-back source: 00 ALU, 01 RAM, 10 PC+4
//   regW       register file write enable
//   ramW       data memory write enable
//   R          data memory read enable
//   Bsel       1 = k onto the B bus, 0 = register B
//   illegal    sticky flag, set when an unsupported opcode is trapped
//   state_dbg  current state encoding
// ---------------------------------------------------------------------------
module legv8_control_fsm #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned LINK_REG = 30,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr,
  input  logic [3:0]         status,
  output logic [DATA_W-1:0]  k,
  output logic [4:0]         DA,
  output logic [4:0]         SA,
  output logic [4:0]         SB,
  output logic [4:0]         FS,
  output logic [3:0]         PS,
  output logic               PCsel,
  output logic [1:0]         dataMux,
  output logic               regW,
  output logic               ramW,
  output logic               R,
  output logic               Bsel,
  output logic               illegal,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CL_ILLEGAL,
    CL_RALU,
    CL_IALU,
    CL_SHIFT,
    CL_LDUR,
    CL_STUR,
    CL_B,
    CL_BL,
    CL_BR,
    CL_CBZ,
    CL_CBNZ
  } iclass_e;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  localparam logic [3:0] PS_HOLD = 4'b0000;
  localparam logic [3:0] PS_INC  = 4'b0001;
  localparam logic [3:0] PS_LOAD = 4'b0010;

  localparam logic [1:0] DM_ALU = 2'b00;
  localparam logic [1:0] DM_RAM = 2'b01;
  localparam logic [1:0] DM_PC4 = 2'b10;

  localparam logic [4:0] LINK_IDX = 5'(LINK_REG);
  localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

  state_e             state_q;
  logic [INSTR_W-1:0] ir_q;
  logic               illegal_q;

  iclass_e            iClass;
  logic [4:0]         aluFs;

  logic [DATA_W-1:0]  immI;
  logic [DATA_W-1:0]  immShift;
  logic [DATA_W-1:0]  immD;
  logic [DATA_W-1:0]  immB;
  logic [DATA_W-1:0]  immCB;

  // Only the Z flag steers control flow; the other ALU flags are not used.
  logic unusedStatus;
  assign unusedStatus = ^status[3:1];

  // Immediate formats carried in the instruction register. Data-transfer and
  // branch offsets are signed; branch offsets are word counts, hence << 2.
  assign immI     = {{(DATA_W-12){1'b0}}, ir_q[21:10]};
  assign immShift = {{(DATA_W-6){1'b0}}, ir_q[15:10]};
  assign immD     = {{(DATA_W-9){ir_q[20]}}, ir_q[20:12]};
  assign immB     = {{(DATA_W-28){ir_q[25]}}, ir_q[25:0], 2'b00};
  assign immCB    = {{(DATA_W-21){ir_q[23]}}, ir_q[23:5], 2'b00};

  // Classify the latched instruction. Opcode widths differ by format, so the
  // shortest opcodes (B/BL, then CB, then I-type) are matched first and the
  // 11-bit R/D-type opcodes last. Anything unmatched is illegal.
  always_comb begin
    iClass = CL_ILLEGAL;
    aluFs  = FS_ADD;
    if (ir_q[31:26] == 6'b000101) begin
      iClass = CL_B;
    end else if (ir_q[31:26] == 6'b100101) begin
      iClass = CL_BL;
    end else if (ir_q[31:24] == 8'hB4) begin
      iClass = CL_CBZ;
    end else if (ir_q[31:24] == 8'hB5) begin
      iClass = CL_CBNZ;
    end else if (ir_q[31:22] == 10'h244) begin
      iClass = CL_IALU;
      aluFs  = FS_ADD;
    end else if (ir_q[31:22] == 10'h344) begin
      iClass = CL_IALU;
      aluFs  = FS_SUB;
    end else begin
      case (ir_q[31:21])
        11'h458: begin iClass = CL_RALU;  aluFs = FS_ADD; end
        11'h658: begin iClass = CL_RALU;  aluFs = FS_SUB; end
        11'h450: begin iClass = CL_RALU;  aluFs = FS_AND; end
        11'h550: begin iClass = CL_RALU;  aluFs = FS_ORR; end
        11'h650: begin iClass = CL_RALU;  aluFs = FS_EOR; end
        11'h69B: begin iClass = CL_SHIFT; aluFs = FS_LSL; end
        11'h69A: begin iClass = CL_SHIFT; aluFs = FS_LSR; end
        11'h7C2: iClass = CL_LDUR;
        11'h7C0: iClass = CL_STUR;
        11'h6B0: iClass = CL_BR;
        default: iClass = CL_ILLEGAL;
      endcase
    end
  end

  // State sequencing. FETCH waits for run before latching the instruction;
  // once latched, run is ignored until the instruction retires. Only loads and
  // stores visit MEM. TRAP is a dead end that only reset leaves.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (run) begin
            ir_q    <= instr;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          if (iClass == CL_ILLEGAL) begin
            state_q   <= TRAP;
            illegal_q <= 1'b1;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (iClass == CL_LDUR || iClass == CL_STUR) begin
            state_q <= MEM;
          end else begin
            state_q <= FETCH;
          end
        end
        MEM:     state_q <= FETCH;
        TRAP:    state_q <= TRAP;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Control word decode from (state, IR, status). Register selects follow the
  // instruction in every state; immediates and all enables are only live in
  // EXEC and MEM. Each instruction produces exactly one cycle with PS != 0:
  // EXEC for ALU and branch instructions, MEM for loads and stores. Writes to
  // XZR are dropped here, and enables are also forced low while reset_n is low
  // so nothing leaks out during the asynchronous reset.
  always_comb begin
    k       = '0;
    DA      = ir_q[4:0];
    SA      = ir_q[9:5];
    SB      = ir_q[20:16];
    FS      = aluFs;
    PS      = PS_HOLD;
    PCsel   = 1'b0;
    dataMux = DM_ALU;
    regW    = 1'b0;
    ramW    = 1'b0;
    R       = 1'b0;
    Bsel    = 1'b0;

    case (iClass)
      CL_STUR: SB = ir_q[4:0];
      CL_BL:   DA = LINK_IDX;
      CL_CBZ, CL_CBNZ: begin
        SA = ZERO_IDX;
        SB = ir_q[4:0];
        FS = FS_ORR;
      end
      default: ;
    endcase

    case (state_q)
      EXEC: begin
        case (iClass)
          CL_RALU: begin
            regW = 1'b1;
            PS   = PS_INC;
          end
          CL_IALU: begin
            k    = immI;
            Bsel = 1'b1;
            regW = 1'b1;
            PS   = PS_INC;
          end
          CL_SHIFT: begin
            k    = immShift;
            Bsel = 1'b1;
            regW = 1'b1;
            PS   = PS_INC;
          end
          CL_LDUR, CL_STUR: begin
            k    = immD;
            Bsel = 1'b1;
          end
          CL_B: begin
            k  = immB;
            PS = PS_LOAD;
          end
          CL_BL: begin
            k       = immB;
            PS      = PS_LOAD;
            dataMux = DM_PC4;
            regW    = 1'b1;
          end
          CL_BR: begin
            PS    = PS_LOAD;
            PCsel = 1'b1;
          end
          CL_CBZ: begin
            k  = immCB;
            PS = status[0] ? PS_LOAD : PS_INC;
          end
          CL_CBNZ: begin
            k  = immCB;
            PS = status[0] ? PS_INC : PS_LOAD;
          end
          default: ;
        endcase
      end
      MEM: begin
        k    = immD;
        Bsel = 1'b1;
        PS   = PS_INC;
        if (iClass == CL_LDUR) begin
          R       = 1'b1;
          dataMux = DM_RAM;
          regW    = 1'b1;
        end else begin
          ramW = 1'b1;
        end
      end
      default: ;
    endcase

    if (DA == ZERO_IDX) begin
      regW = 1'b0;
    end
    if (!reset_n) begin
      regW = 1'b0;
      ramW = 1'b0;
      R    = 1'b0;
      PS   = PS_HOLD;
    end
  end

  assign illegal   = illegal_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_legv8_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_legv8_control_fsm
//
// Self-checking bench for legv8_control_fsm. Instructions are built from
// mnemonic + fields, encoded into machine words, and the expected control word
// for each cycle is worked out from the mnemonic and field values directly.
// Directed cases cover the documented examples; a randomized loop follows.
// ---------------------------------------------------------------------------
module tb_legv8_control_fsm;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_ORR  = 3;
  localparam int OP_EOR  = 4;
  localparam int OP_LSL  = 5;
  localparam int OP_LSR  = 6;
  localparam int OP_ADDI = 7;
  localparam int OP_SUBI = 8;
  localparam int OP_LDUR = 9;
  localparam int OP_STUR = 10;
  localparam int OP_B    = 11;
  localparam int OP_BL   = 12;
  localparam int OP_BR   = 13;
  localparam int OP_CBZ  = 14;
  localparam int OP_CBNZ = 15;

  typedef struct {
    int         op;
    logic [4:0] rd;
    logic [4:0] rn;
    logic [4:0] rm;
    logic [5:0] shamt;
    int         imm;
  } instr_t;

  typedef struct {
    logic [2:0]  state;
    logic [63:0] k;
    logic [4:0]  da;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  fs;
    logic [3:0]  ps;
    logic        pcsel;
    logic [1:0]  dmux;
    logic        regw;
    logic        ramw;
    logic        rden;
    logic        bsel;
    bit          chkK;
    bit          chkDA;
    bit          chkSA;
    bit          chkSB;
    bit          chkFS;
    bit          chkBsel;
    bit          chkDmux;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        run = 1'b0;
  logic [31:0] instr = '0;
  logic [3:0]  status = '0;
  logic [63:0] k;
  logic [4:0]  DA, SA, SB, FS;
  logic [3:0]  PS;
  logic        PCsel;
  logic [1:0]  dataMux;
  logic        regW, ramW, R, Bsel, illegal;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  legv8_control_fsm dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .run       (run),
    .instr     (instr),
    .status    (status),
    .k         (k),
    .DA        (DA),
    .SA        (SA),
    .SB        (SB),
    .FS        (FS),
    .PS        (PS),
    .PCsel     (PCsel),
    .dataMux   (dataMux),
    .regW      (regW),
    .ramW      (ramW),
    .R         (R),
    .Bsel      (Bsel),
    .illegal   (illegal),
    .state_dbg (state_dbg)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Machine-word encoding of a mnemonic plus its fields.
  function automatic logic [31:0] encode(instr_t d);
    logic [31:0] u;
    logic [31:0] w;
    u = d.imm;
    case (d.op)
      OP_ADD:  w = {11'h458, d.rm, d.shamt, d.rn, d.rd};
      OP_SUB:  w = {11'h658, d.rm, d.shamt, d.rn, d.rd};
      OP_AND:  w = {11'h450, d.rm, d.shamt, d.rn, d.rd};
      OP_ORR:  w = {11'h550, d.rm, d.shamt, d.rn, d.rd};
      OP_EOR:  w = {11'h650, d.rm, d.shamt, d.rn, d.rd};
      OP_LSL:  w = {11'h69B, d.rm, d.shamt, d.rn, d.rd};
      OP_LSR:  w = {11'h69A, d.rm, d.shamt, d.rn, d.rd};
      OP_ADDI: w = {10'h244, u[11:0], d.rn, d.rd};
      OP_SUBI: w = {10'h344, u[11:0], d.rn, d.rd};
      OP_LDUR: w = {11'h7C2, u[8:0], 2'b00, d.rn, d.rd};
      OP_STUR: w = {11'h7C0, u[8:0], 2'b00, d.rn, d.rd};
      OP_B:    w = {6'b000101, u[25:0]};
      OP_BL:   w = {6'b100101, u[25:0]};
      OP_BR:   w = {11'h6B0, 5'h1F, 6'h00, d.rn, 5'h00};
      OP_CBZ:  w = {8'hB4, u[18:0], d.rd};
      OP_CBNZ: w = {8'hB5, u[18:0], d.rd};
      default: w = '0;
    endcase
    return w;
  endfunction

  // Whether a raw word belongs to the supported instruction set.
  function automatic bit legalWord(logic [31:0] w);
    logic [10:0] op11;
    logic [9:0]  op10;
    logic [7:0]  op8;
    logic [5:0]  op6;
    op11 = w[31:21];
    op10 = w[31:22];
    op8  = w[31:24];
    op6  = w[31:26];
    if (op6 == 6'b000101 || op6 == 6'b100101) return 1'b1;
    if (op8 == 8'hB4 || op8 == 8'hB5) return 1'b1;
    if (op10 == 10'h244 || op10 == 10'h344) return 1'b1;
    if (op11 inside {11'h458, 11'h658, 11'h450, 11'h550, 11'h650,
                     11'h69B, 11'h69A, 11'h7C2, 11'h7C0, 11'h6B0}) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] fsOf(int op);
    case (op)
      OP_SUB, OP_SUBI: return 5'b01001;
      OP_AND:          return 5'b00000;
      OP_ORR:          return 5'b00100;
      OP_EOR:          return 5'b01100;
      OP_LSL:          return 5'b10000;
      OP_LSR:          return 5'b10100;
      default:         return 5'b01000;
    endcase
  endfunction

  // Expected control word in EXEC (memPhase=0) or MEM (memPhase=1).
  function automatic exp_t model(instr_t d, logic z, bit memPhase);
    exp_t e;
    bit   taken;
    e = '{default: '0};
    e.state = memPhase ? 3'd3 : 3'd2;
    case (d.op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_LSL, OP_LSR, OP_ADDI, OP_SUBI: begin
        e.da = d.rd;  e.chkDA = 1;
        e.sa = d.rn;  e.chkSA = 1;
        e.fs = fsOf(d.op); e.chkFS = 1;
        e.ps = 4'd1;
        e.regw = (d.rd != 5'd31);
        e.dmux = 2'd0; e.chkDmux = 1;
        e.chkBsel = 1;
        if (d.op <= OP_EOR) begin
          e.sb = d.rm; e.chkSB = 1;
          e.bsel = 1'b0;
        end else if (d.op == OP_LSL || d.op == OP_LSR) begin
          e.sb = d.rm; e.chkSB = 1;
          e.bsel = 1'b1;
          e.k = 64'(d.shamt); e.chkK = 1;
        end else begin
          e.bsel = 1'b1;
          e.k = 64'(d.imm); e.chkK = 1;
        end
      end
      OP_LDUR, OP_STUR: begin
        e.k = 64'(longint'(d.imm)); e.chkK = 1;
        e.fs = 5'b01000; e.chkFS = 1;
        e.bsel = 1'b1; e.chkBsel = 1;
        e.sa = d.rn; e.chkSA = 1;
        if (d.op == OP_STUR) begin
          e.sb = d.rd; e.chkSB = 1;
        end
        if (memPhase) begin
          e.ps = 4'd1;
          if (d.op == OP_LDUR) begin
            e.rden = 1'b1;
            e.dmux = 2'd1; e.chkDmux = 1;
            e.regw = (d.rd != 5'd31);
            e.da = d.rd; e.chkDA = 1;
          end else begin
            e.ramw = 1'b1;
          end
        end
      end
      OP_B, OP_BL: begin
        e.k = 64'(longint'(d.imm) * 4); e.chkK = 1;
        e.ps = 4'd2;
        e.pcsel = 1'b0;
        if (d.op == OP_BL) begin
          e.da = 5'd30; e.chkDA = 1;
          e.dmux = 2'd2; e.chkDmux = 1;
          e.regw = 1'b1;
        end
      end
      OP_BR: begin
        e.sa = d.rn; e.chkSA = 1;
        e.ps = 4'd2;
        e.pcsel = 1'b1;
      end
      default: begin
        e.sa = 5'd31; e.chkSA = 1;
        e.sb = d.rd;  e.chkSB = 1;
        e.fs = 5'b00100; e.chkFS = 1;
        e.bsel = 1'b0; e.chkBsel = 1;
        e.k = 64'(longint'(d.imm) * 4); e.chkK = 1;
        taken = (d.op == OP_CBZ) ? (z == 1'b1) : (z == 1'b0);
        e.ps = taken ? 4'd2 : 4'd1;
        e.pcsel = 1'b0;
      end
    endcase
    return e;
  endfunction

  task automatic checkPhase(input string tag, input exp_t e);
    checkOutput({tag, ".state"}, state_dbg, e.state);
    checkOutput({tag, ".PS"}, PS, e.ps);
    checkOutput({tag, ".regW"}, regW, e.regw);
    checkOutput({tag, ".ramW"}, ramW, e.ramw);
    checkOutput({tag, ".R"}, R, e.rden);
    if (e.ps == 4'd2) checkOutput({tag, ".PCsel"}, PCsel, e.pcsel);
    if (e.chkK)    checkOutput({tag, ".k"}, k, e.k);
    if (e.chkDA)   checkOutput({tag, ".DA"}, DA, e.da);
    if (e.chkSA)   checkOutput({tag, ".SA"}, SA, e.sa);
    if (e.chkSB)   checkOutput({tag, ".SB"}, SB, e.sb);
    if (e.chkFS)   checkOutput({tag, ".FS"}, FS, e.fs);
    if (e.chkBsel) checkOutput({tag, ".Bsel"}, Bsel, e.bsel);
    if (e.chkDmux) checkOutput({tag, ".dataMux"}, dataMux, e.dmux);
  endtask

  // States where every enable is quiet and k/Bsel/dataMux sit at zero.
  task automatic checkIdle(input string tag, input logic [2:0] st);
    checkOutput({tag, ".state"}, state_dbg, st);
    checkOutput({tag, ".PS"}, PS, 4'd0);
    checkOutput({tag, ".regW"}, regW, 1'b0);
    checkOutput({tag, ".ramW"}, ramW, 1'b0);
    checkOutput({tag, ".R"}, R, 1'b0);
    checkOutput({tag, ".k"}, k, 64'd0);
    checkOutput({tag, ".Bsel"}, Bsel, 1'b0);
    checkOutput({tag, ".dataMux"}, dataMux, 2'd0);
  endtask

  // Called at a falling edge; leaves at a falling edge in FETCH.
  task automatic applyReset();
    reset_n = 1'b0;
    run     = 1'b0;
    #1;
    checkIdle("reset", 3'd0);
    checkOutput("reset.illegal", illegal, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkIdle("postReset", 3'd0);
    @(negedge clock);
  endtask

  // Runs one instruction through the unit from FETCH. zForce: -1 random Z,
  // otherwise the Z value applied during EXEC/MEM. Illegal words are held in
  // TRAP for ten cycles and then cleared by reset.
  task automatic applyStimulus(input logic [31:0] word, input instr_t d, input bit legal,
                               input int zForce);
    int   stall;
    logic z;
    stall = $urandom_range(0, 2);
    for (int i = 0; i < stall; i++) begin
      run = 1'b0;
      instr = $urandom;
      status = 4'($urandom);
      #1;
      checkIdle("stall", 3'd0);
      @(negedge clock);
    end
    run = 1'b1;
    instr = word;
    status = 4'($urandom);
    #1;
    checkIdle("fetch", 3'd0);
    @(negedge clock);
    run = 1'($urandom);
    instr = $urandom;
    #1;
    checkIdle("decode", 3'd1);
    @(negedge clock);
    if (!legal) begin
      for (int i = 0; i < 10; i++) begin
        run = 1'b1;
        instr = $urandom;
        status = 4'($urandom);
        #1;
        checkIdle("trap", 3'd7);
        checkOutput("trap.illegal", illegal, 1'b1);
        @(negedge clock);
      end
      applyReset();
    end else begin
      z = (zForce < 0) ? 1'($urandom) : 1'(zForce);
      status = {3'($urandom), z};
      run = 1'($urandom);
      #1;
      checkPhase("exec", model(d, z, 1'b0));
      if (d.op == OP_LDUR || d.op == OP_STUR) begin
        @(negedge clock);
        status = 4'($urandom);
        #1;
        checkPhase("mem", model(d, status[0], 1'b1));
      end
      @(negedge clock);
      checkOutput("retire.illegal", illegal, 1'b0);
    end
  endtask

  task automatic randInstr(output instr_t d);
    int r;
    r = int'($urandom);
    d.op    = int'($urandom_range(0, 15));
    d.rd    = 5'($urandom);
    d.rn    = 5'($urandom);
    d.rm    = 5'($urandom);
    d.shamt = 6'($urandom);
    if ($urandom_range(0, 7) == 0) d.rd = 5'd31;
    case (d.op)
      OP_ADDI, OP_SUBI:   d.imm = int'($urandom_range(0, 4095));
      OP_LDUR, OP_STUR:   d.imm = (r <<< 23) >>> 23;
      OP_B, OP_BL:        d.imm = (r <<< 6) >>> 6;
      OP_CBZ, OP_CBNZ:    d.imm = (r <<< 13) >>> 13;
      default:            d.imm = 0;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    instr_t      d;
    logic [31:0] w;

    // Asynchronous reset asserted between clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    checkIdle("init", 3'd0);
    checkOutput("init.illegal", illegal, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // ADD X7,X1,X2
    d = '{op: OP_ADD, rd: 5'd7, rn: 5'd1, rm: 5'd2, shamt: 6'd0, imm: 0};
    applyStimulus(32'h8B020027, d, 1'b1, -1);

    // LDUR X3,[X1,#-8]
    d = '{op: OP_LDUR, rd: 5'd3, rn: 5'd1, rm: 5'd0, shamt: 6'd0, imm: -8};
    applyStimulus(encode(d), d, 1'b1, -1);

    // CBZ X4,+3 taken, then not taken
    d = '{op: OP_CBZ, rd: 5'd4, rn: 5'd0, rm: 5'd0, shamt: 6'd0, imm: 3};
    applyStimulus(encode(d), d, 1'b1, 1);
    applyStimulus(encode(d), d, 1'b1, 0);

    // CBNZ both ways
    d = '{op: OP_CBNZ, rd: 5'd9, rn: 5'd0, rm: 5'd0, shamt: 6'd0, imm: -5};
    applyStimulus(encode(d), d, 1'b1, 0);
    applyStimulus(encode(d), d, 1'b1, 1);

    // BL +1 and ADDI X31,X1,#5
    d = '{op: OP_BL, rd: 5'd0, rn: 5'd0, rm: 5'd0, shamt: 6'd0, imm: 1};
    applyStimulus(encode(d), d, 1'b1, -1);
    d = '{op: OP_ADDI, rd: 5'd31, rn: 5'd1, rm: 5'd0, shamt: 6'd0, imm: 5};
    applyStimulus(encode(d), d, 1'b1, -1);

    // All-zero word traps
    applyStimulus(32'h0000_0000, d, 1'b0, -1);

    // Reset pulsed during STUR EXEC: the store must never reach RAM.
    d = '{op: OP_STUR, rd: 5'd5, rn: 5'd2, rm: 5'd0, shamt: 6'd0, imm: 16};
    run = 1'b1;
    instr = encode(d);
    #1;
    checkIdle("sturRst.fetch", 3'd0);
    @(negedge clock);
    #1;
    checkIdle("sturRst.decode", 3'd1);
    @(negedge clock);
    #1;
    checkOutput("sturRst.exec.state", state_dbg, 3'd2);
    reset_n = 1'b0;
    run = 1'b0;
    #1;
    checkOutput("sturRst.state", state_dbg, 3'd0);
    checkOutput("sturRst.ramW", ramW, 1'b0);
    checkOutput("sturRst.PS", PS, 4'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("sturRst.after.state", state_dbg, 3'd0);
    checkOutput("sturRst.after.ramW", ramW, 1'b0);
    @(negedge clock);

    // Randomized instruction stream with occasional illegal words.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        w = $urandom;
        for (int t = 0; t < 100 && legalWord(w); t++) w = $urandom;
        if (!legalWord(w)) applyStimulus(w, d, 1'b0, -1);
      end else begin
        randInstr(d);
        applyStimulus(encode(d), d, 1'b1, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
